// File: rtl/pid_pkg.sv
// Shared types and helpers for the line-follower PID controller (pid_line_ctrl).
package pid_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_MUL_P,
        ST_MUL_I,
        ST_MUL_D,
        ST_SUM
    } pid_state_t;

    function automatic int sensor_weight(input int idx, input int n);
        return 2 * idx - (n - 1);
    endfunction

    function automatic int e_max(input int n);
        return (n * n) / 4;
    endfunction

    function automatic int err_w(input int n);
        return $clog2(e_max(n) + 1) + 1;
    endfunction

    function automatic longint sat_s(input longint v, input int w);
        longint hi;
        longint lo;
        hi = (longint'(1) <<< (w - 1)) - 1;
        lo = -(longint'(1) <<< (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/pid_err_enc.sv
// Sensor synchroniser and weighted position encoder.
// With PID_LOST_LINE_EN, lost_err steers back toward the side the line was last seen.
module pid_err_enc
    import pid_pkg::*;
#(
    parameter int N_SENSORS = 4,
    parameter int ERR_W     = err_w(N_SENSORS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_SENSORS-1:0] sensors,
    output logic [ERR_W-1:0]     err,
    output logic [ERR_W-1:0]     lost_err,
    output logic                 lost
);

    logic [N_SENSORS-1:0]    sync_q1;
    logic [N_SENSORS-1:0]    sync_q2;
    logic signed [ERR_W-1:0] raw_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= sensors;
            sync_q2 <= sync_q1;
        end
    end

    // Every subset sum of the weights stays within +/-E_MAX, so no partial sum overflows.
    always_comb begin
        raw_err = '0;
        for (int i = 0; i < N_SENSORS; i++) begin
            if (sync_q2[i]) raw_err = raw_err + ERR_W'(sensor_weight(i, N_SENSORS));
        end
    end

    assign err  = raw_err;
    assign lost = (sync_q2 == '0);

`ifdef PID_LOST_LINE_EN
    localparam logic signed [ERR_W-1:0] E_POS = ERR_W'(e_max(N_SENSORS));

    logic last_neg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_neg <= 1'b0;
        end else if (raw_err != '0) begin
            last_neg <= raw_err[ERR_W-1];
        end
    end

    assign lost_err = last_neg ? -E_POS : E_POS;
`else
    assign lost_err = '0;
`endif

endmodule

// File: rtl/pid_line_ctrl.sv
// Parametrised steering PID: sample divider, sequencing FSM, one shared multiplier.
// Optional lost-line recovery is enabled by defining PID_LOST_LINE_EN.
//
//  state   | meaning
//  IDLE    | wait for sample tick
//  CAPTURE | latch err, gated gains, ki switch
//  MUL_P   | p = kp*err
//  MUL_I   | integ = sat(integ+err), i = ki*integ
//  MUL_D   | d = kd*(err-e_prev), register saturated sum, raise out_valid
//  SUM     | out_valid high for this cycle
module pid_line_ctrl
    import pid_pkg::*;
#(
    parameter int N_SENSORS  = 4,
    parameter int OUT_W      = 13,
    parameter int GAIN_W     = 8,
    parameter int SHIFT      = 0,
    parameter int INT_LIM    = 1024,
    parameter int SAMPLE_DIV = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_SENSORS-1:0] sensors,
    input  logic                 kp_sw,
    input  logic                 ki_sw,
    input  logic                 kd_sw,
    input  logic [GAIN_W-1:0]    kp,
    input  logic [GAIN_W-1:0]    ki,
    input  logic [GAIN_W-1:0]    kd,
    output logic [OUT_W-1:0]     pid_output,
    output logic                 out_valid
);

    localparam int ERR_W = err_w(N_SENSORS);
    localparam int INT_W = $clog2(INT_LIM + 1) + 1;
    localparam int OPD_W = (INT_W > ERR_W + 1) ? INT_W : ERR_W + 1;
    localparam int IS_W  = OPD_W + 1;
    localparam int PRD_W = GAIN_W + 1 + OPD_W;
    localparam int SUM_W = PRD_W + 2;
    localparam int CNT_W = $clog2(SAMPLE_DIV);

    localparam logic signed [IS_W-1:0] LIM_P = IS_W'(INT_LIM);
    localparam logic signed [IS_W-1:0] LIM_N = -LIM_P;

    if (SAMPLE_DIV < 8) begin : g_bad_div
        $error("pid_line_ctrl: SAMPLE_DIV must be at least 8");
    end
    if ((N_SENSORS % 2) != 0 || N_SENSORS < 4 || N_SENSORS > 16) begin : g_bad_n
        $error("pid_line_ctrl: N_SENSORS must be even, 4..16");
    end

    pid_state_t              state;
    logic [CNT_W-1:0]        cnt;
    logic                    tick;
    logic signed [ERR_W-1:0] err, lost_err, err_q, e_prev;
    logic                    lost;
    logic [GAIN_W-1:0]       kp_q, ki_q, kd_q;
    logic                    ki_on_q;
    logic signed [INT_W-1:0] integ_q, integ_nxt;
    logic signed [IS_W-1:0]  integ_sum;
    logic signed [PRD_W-1:0] p_q, i_q, mul_y;
    logic [GAIN_W-1:0]       mul_a;
    logic signed [OPD_W-1:0] mul_b;
    logic signed [SUM_W-1:0] pid_sum, pid_shift;

    pid_err_enc #(
        .N_SENSORS (N_SENSORS),
        .ERR_W     (ERR_W)
    ) u_enc (
        .clk      (clk),
        .rst_n    (rst_n),
        .sensors  (sensors),
        .err      (err),
        .lost_err (lost_err),
        .lost     (lost)
    );

    always_comb begin
        integ_sum = IS_W'(integ_q) + IS_W'(err_q);
        integ_nxt = '0;
        if (ki_on_q) begin
            if (integ_sum > LIM_P)      integ_nxt = INT_W'(LIM_P);
            else if (integ_sum < LIM_N) integ_nxt = INT_W'(LIM_N);
            else                        integ_nxt = INT_W'(integ_sum);
        end
    end

    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state)
            ST_MUL_P: begin
                mul_a = kp_q;
                mul_b = OPD_W'(err_q);
            end
            ST_MUL_I: begin
                mul_a = ki_q;
                mul_b = OPD_W'(integ_nxt);
            end
            ST_MUL_D: begin
                mul_a = kd_q;
                mul_b = OPD_W'(err_q) - OPD_W'(e_prev);
            end
            default: ;
        endcase
    end

    assign mul_y = PRD_W'($signed({1'b0, mul_a})) * PRD_W'(mul_b);

    // The d product feeds the sum directly so the output lands as SUM is entered.
    always_comb begin
        pid_sum   = SUM_W'(p_q) + SUM_W'(i_q) + SUM_W'(mul_y);
        pid_shift = pid_sum >>> SHIFT;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            tick       <= 1'b0;
            err_q      <= '0;
            e_prev     <= '0;
            kp_q       <= '0;
            ki_q       <= '0;
            kd_q       <= '0;
            ki_on_q    <= 1'b0;
            integ_q    <= '0;
            p_q        <= '0;
            i_q        <= '0;
            pid_output <= '0;
            out_valid  <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            tick      <= (cnt == CNT_W'(1));
            cnt       <= (cnt == '0) ? CNT_W'(SAMPLE_DIV - 1) : cnt - CNT_W'(1);
            case (state)
                ST_IDLE: begin
                    if (tick) state <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    err_q   <= lost ? lost_err : err;
                    kp_q    <= kp_sw ? kp : '0;
                    ki_q    <= ki_sw ? ki : '0;
                    kd_q    <= kd_sw ? kd : '0;
                    ki_on_q <= ki_sw;
                    state   <= ST_MUL_P;
                end
                ST_MUL_P: begin
                    p_q   <= mul_y;
                    state <= ST_MUL_I;
                end
                ST_MUL_I: begin
                    integ_q <= integ_nxt;
                    i_q     <= mul_y;
                    state   <= ST_MUL_D;
                end
                ST_MUL_D: begin
                    e_prev     <= err_q;
                    pid_output <= OUT_W'(sat_s(longint'(pid_shift), OUT_W));
                    out_valid  <= 1'b1;
                    state      <= ST_SUM;
                end
                ST_SUM: begin
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
